div_seq_unit: RTL and testbench
===============================

// Module: div_seq_unit
// PURPOSE
//   Multicycle signed divider that answers the control unit's start/ready divide handshake.
//   Operands come from the A and B registers (dividend a, divisor b).
//   Remainder goes to HI, quotient to LO, following MIPS DIV semantics.
//   Division by zero raises div_zero to the control unit for the exception path.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; iteration count equals WIDTH
// PORTS
//   clk       in   1      system clock; all state changes on rising edge
//   reset     in   1      synchronous, active-high reset
//   start     in   1      request; sampled only in IDLE
//   a         in   WIDTH  dividend, signed two's complement
//   b         in   WIDTH  divisor, signed two's complement
//   hi        out  WIDTH  remainder of last completed division
//   lo        out  WIDTH  quotient of last completed division
//   ready     out  1      one-cycle completion pulse
//   div_zero  out  1      one-cycle pulse, coincident with ready, when b was 0
//   busy      out  1      high in every state except IDLE
// BEHAVIOUR
//   Reset (synchronous, active-high)
//   - State goes to IDLE. hi, lo, ready, div_zero, busy and all internal registers go to 0.
//   - Reset wins over every other event, including mid-RUN and in the DONE cycle.
//   States
//   - IDLE: busy=0.
//     - On an edge with start=1 and b!=0: capture a and b, go to RUN.
//       Capture sign_q = a[W-1]^b[W-1] and sign_r = a[W-1].
//       Capture |a| into the quotient shift reg, |b| into the divisor reg, clear the partial remainder.
//       Set count = WIDTH.
//     - On an edge with start=1 and b==0: go to DONE with div_zero=1. hi and lo are NOT updated.
//   - RUN: one restoring step per edge.
//     - {rem,q} <<= 1.
//     - If rem >= divisor: rem -= divisor and q[0] = 1.
//     - count decrements each step. After the WIDTH-th step, go to FIX.
//   - FIX: one edge.
//     - lo <= sign_q ? -q : q.
//     - hi <= sign_r ? -rem : rem.
//     - Set ready=1 and go to DONE.
//   - DONE: ready=1 for exactly this one cycle.
//     - div_zero=1 only on the divide-by-zero path.
//     - The next edge returns to IDLE with ready=0 and div_zero=0.
//     - start is ignored in DONE.
//   Latency
//   - Normal path: ready high in the cycle following edge E+WIDTH+1, where E is the start edge (34 edges for WIDTH=32).
//   - Zero divisor: ready high in the cycle following edge E.
//   Handshake
//   - start is ignored while busy=1 and is never queued.
//   - a and b may change after edge E; the captured values are used.
//   - hi and lo hold their values until the next FIX edge or reset.
//   Arithmetic
//   - The quotient truncates toward zero. The remainder takes the dividend's sign.
//   - The magnitude datapath is WIDTH bits wide, with rem plus 1 guard bit for the compare.
//   - |0x80000000| is handled as unsigned 0x80000000.
//   - 0x80000000 / -1: lo = 0x80000000 and hi = 0. No overflow flag is raised.
// TESTING
//   T1: a=7, b=2, start pulse -> after 34 edges ready=1 for 1 cycle, lo=3, hi=1, div_zero=0.
//   T2: a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
//   T3: preload lo=3, hi=1 via T1; then a=5, b=0 -> next cycle ready=1 and div_zero=1, hi/lo still 1/3, busy back to 0.
//   T4: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. a=0, b=9 -> lo=0, hi=0.
//   T5: reset=1 on the 10th RUN edge -> next cycle busy=0, ready=0, hi=lo=0. A new start with a=100, b=7 then gives lo=14, hi=2.
//   T6: start held high through a whole operation with a=9, b=3 -> exactly one ready pulse (lo=3, hi=0); a new operation begins only on the first IDLE edge after DONE.

Source files
------------

// File: rtl/div_seq_unit.sv
// Multicycle signed restoring divider with a start/ready handshake.
// Quotient goes to lo and remainder to hi; a zero divisor raises a div_zero pulse.
module div_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ready,
    output logic             div_zero,
    output logic             busy
);
    // state  | meaning
    // IDLE   | waiting for start
    // RUN    | one restoring quotient bit per edge, count down to 1
    // FIX    | apply result signs and load hi/lo
    // DONE   | single-cycle ready (and div_zero) pulse
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;
    logic             zero_flag;

    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // Guard bit keeps the shifted remainder compare exact; the difference always fits WIDTH bits.
    assign trial    = {rem, q[WIDTH-1]};
    assign trial_ge = trial >= {1'b0, divisor};
    assign rem_sub  = trial[WIDTH-1:0] - divisor;
    assign a_abs    = a[WIDTH-1] ? -a : a;
    assign b_abs    = b[WIDTH-1] ? -b : b;

    assign busy     = (state != S_IDLE);
    assign ready    = (state == S_DONE);
    assign div_zero = (state == S_DONE) && zero_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            q         <= '0;
            divisor   <= '0;
            rem       <= '0;
            count     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            zero_flag <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            zero_flag <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            sign_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                            sign_r    <= a[WIDTH-1];
                            q         <= a_abs;
                            divisor   <= b_abs;
                            rem       <= '0;
                            count     <= CW'(WIDTH);
                            zero_flag <= 1'b0;
                            state     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem   <= trial_ge ? rem_sub : trial[WIDTH-1:0];
                    q     <= {q[WIDTH-2:0], trial_ge};
                    count <= count - CW'(1);
                    if (count == CW'(1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    lo    <= sign_q ? -q : q;
                    hi    <= sign_r ? -rem : rem;
                    state <= S_DONE;
                end
                default: begin
                    zero_flag <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit: directed cases plus random operands
// compared against plain signed arithmetic.
module tb_div_seq_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic [W-1:0] hi, lo;
    logic         ready, div_zero, busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dz = 1'b0;

    div_seq_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .hi(hi), .lo(lo), .ready(ready), .div_zero(div_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Truncating signed division; longint keeps min/-1 representable, and its low
    // 32 bits give the wrapped quotient 0x80000000.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        longint sa;
        longint sb;
        sa = $signed(ma);
        sb = $signed(mb);
        if (mb == '0) begin
            exp_dz = 1'b1;
        end else begin
            exp_dz = 1'b0;
            exp_lo = W'(sa / sb);
            exp_hi = W'(sa % sb);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input string tag);
        int edges;
        int exp_lat;
        @(negedge clk);
        a = ta; b = tb_; start = 1'b1;
        model(ta, tb_);
        exp_lat = (tb_ == '0) ? 0 : W + 1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        edges = 0;
        while (!ready && edges < 60) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, ".latency"}, 64'(edges), 64'(exp_lat));
        check({tag, ".ready"}, 64'(ready), 64'd1);
        check({tag, ".div_zero"}, 64'(div_zero), 64'(exp_dz));
        check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
        check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        @(posedge clk); #1;
        check({tag, ".ready_drop"}, 64'(ready), 64'd0);
        check({tag, ".dz_drop"}, 64'(div_zero), 64'd0);
        check({tag, ".idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.hi", 64'(hi), 64'd0);
        check("rst.lo", 64'(lo), 64'd0);
        check("rst.ready", 64'(ready), 64'd0);
        check("rst.dz", 64'(div_zero), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        reset = 1'b0;

        run_op(32'd7, 32'd2, "t1");
        check("t1.lo_const", 64'(lo), 64'd3);
        check("t1.hi_const", 64'(hi), 64'd1);
        run_op(32'hFFFF_FFF9, 32'd2, "t2a");
        check("t2a.lo_const", 64'(lo), 64'hFFFF_FFFD);
        check("t2a.hi_const", 64'(hi), 64'hFFFF_FFFF);
        run_op(32'd7, 32'hFFFF_FFFE, "t2b");
        check("t2b.lo_const", 64'(lo), 64'hFFFF_FFFD);
        check("t2b.hi_const", 64'(hi), 64'd1);
        run_op(32'd7, 32'd2, "t3pre");
        run_op(32'd5, 32'd0, "t3");
        check("t3.lo_hold", 64'(lo), 64'd3);
        check("t3.hi_hold", 64'(hi), 64'd1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, "t4a");
        check("t4a.lo_const", 64'(lo), 64'h8000_0000);
        check("t4a.hi_const", 64'(hi), 64'd0);
        run_op(32'd0, 32'd9, "t4b");
        run_op(32'h8000_0000, 32'd1, "min_by_1");
        run_op(32'h7FFF_FFFF, 32'h8000_0000, "max_by_min");

        // T5: reset on the 10th RUN edge
        @(negedge clk);
        a = 32'd1234567; b = 32'd89; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5.busy", 64'(busy), 64'd0);
        check("t5.ready", 64'(ready), 64'd0);
        check("t5.hi", 64'(hi), 64'd0);
        check("t5.lo", 64'(lo), 64'd0);
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        run_op(32'd100, 32'd7, "t5b");
        check("t5b.lo_const", 64'(lo), 64'd14);
        check("t5b.hi_const", 64'(hi), 64'd2);

        // T6: start held high through an entire operation
        @(negedge clk);
        a = 32'd9; b = 32'd3; start = 1'b1;
        pulses = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        check("t6.pulses", 64'(pulses), 64'd1);
        check("t6.lo", 64'(lo), 64'd3);
        check("t6.hi", 64'(hi), 64'd0);
        @(posedge clk); #1;
        check("t6.idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("t6.restart", 64'(busy), 64'd1);
        start = 1'b0;
        pulses = 0;
        while (!ready && pulses < 60) begin
            @(posedge clk); #1;
            pulses++;
        end
        check("t6.second_done", 64'(ready), 64'd1);
        @(posedge clk); #1;
        exp_lo = 32'd3; exp_hi = 32'd0;

        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = W'($urandom_range(1, 20));
                1: rb = -W'($urandom_range(1, 20));
                2: rb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
                default: rb = W'($urandom) >> $urandom_range(0, 30);
            endcase
            run_op(ra, rb, $sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
